cordic_front: RTL and testbench

- Command-side sequencer placed directly upstream of the CORDIC coprocessor; also consumes its result.
- Accepts a software request: a signed 16-bit integer angle in degrees, any range, plus a function code.
- Reduces the angle to 0–90°, issues one request to CORDIC, waits for the result, applies the quadrant sign correction, and holds the final value for readout.

---
 rtl/cordic_front_if.sv | 37 +++
 rtl/cordic_front.sv | 198 +++++++++++++++++++
 tb/tb_cordic_front.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_front_if.sv
// Bus bundle between software-side requester, the cordic_front sequencer,
// the CORDIC coprocessor and the result consumer.
// slave  : the sequencer's view (accepts commands, drives CORDIC and results)
// master : the surrounding system's view
interface cordic_front_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [15:0] cmd_angle;
    logic [1:0]         cmd_func;
    logic [15:0]        cmd_another;

    logic               cordic_valid;
    logic [15:0]        cordic_angle;
    logic [3:0]         cordic_select;
    logic [15:0]        cordic_another;
    logic signed [15:0] cordic_out;
    logic               cordic_out_valid;

    logic               res_valid;
    logic               res_ready;
    logic signed [15:0] res_data;
    logic               res_err;

    modport slave (
        input  cmd_valid, cmd_angle, cmd_func, cmd_another,
        input  cordic_out, cordic_out_valid, res_ready,
        output cmd_ready, cordic_valid, cordic_angle, cordic_select, cordic_another,
        output res_valid, res_data, res_err
    );

    modport master (
        output cmd_valid, cmd_angle, cmd_func, cmd_another,
        output cordic_out, cordic_out_valid, res_ready,
        input  cmd_ready, cordic_valid, cordic_angle, cordic_select, cordic_another,
        input  res_valid, res_data, res_err
    );
endinterface

// File: rtl/cordic_front.sv
// cordic_front: command sequencer in front of a CORDIC coprocessor.
// Takes a degree angle of any 16-bit value, folds it into 0..359 by repeated
// +/-360 steps, maps it onto the first quadrant, issues one CORDIC request,
// waits (bounded by TIMEOUT_CYC) for the result, restores the quadrant sign
// and holds the final Q7.8 value until the consumer takes it.
// Optional build macro CORDIC_FRONT_STATS_EN adds stat_req / stat_tmo counters.
module cordic_front #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    cordic_front_if.slave bus
`ifdef CORDIC_FRONT_STATS_EN
    ,
    output logic [15:0] stat_req,
    output logic [15:0] stat_tmo
`endif
);
    localparam int STEP_DEG = 360;
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic signed [16:0] STEP = 17'(STEP_DEG);
    localparam logic signed [16:0] R_MAX = 17'(STEP_DEG - 1);

    typedef enum logic [2:0] {IDLE, REDUCE, QUAD, ISSUE, WAIT, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic               cmd_ready, cordic_valid, res_valid;

    logic signed [16:0] r;
    logic signed [15:0] r_lo;
    logic [1:0]         func;
    logic               neg;
    logic signed [15:0] cap;
    logic [CNT_W-1:0]   cnt;

    logic [15:0]        angle_q;
    logic [3:0]         sel_q;
    logic [15:0]        another_q;
    logic signed [15:0] res_q;
    logic               err_q;

    logic               accept, r_low, r_high, tmo_hit;
    logic signed [15:0] quad_a;
    logic               quad_neg, tan_sing;

    // Two's complement negate; -32768 has no positive twin, so clamp it.
    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] x);
        logic signed [15:0] y;
        if (x == 16'sh8000) y = 16'sh7FFF;
        else                y = -x;
        return y;
    endfunction

    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign r_low   = r < 17'sd0;
    assign r_high  = r > R_MAX;
    assign r_lo    = r[15:0];
    assign tmo_hit = (cnt == CNT_LAST);

    // Quadrant fold of r (0..359) to 0..90 plus the sign flip each function needs there
    always_comb begin
        quad_a   = '0;
        quad_neg = 1'b0;
        tan_sing = 1'b0;
        if (r_lo <= 16'sd90) begin
            quad_a = r_lo;
        end else if (r_lo <= 16'sd180) begin
            quad_a   = 16'sd180 - r_lo;
            quad_neg = (func == 2'd1) || (func == 2'd2);
        end else if (r_lo <= 16'sd270) begin
            quad_a   = r_lo - 16'sd180;
            quad_neg = (func == 2'd0) || (func == 2'd1);
        end else begin
            quad_a   = 16'sd360 - r_lo;
            quad_neg = (func == 2'd0) || (func == 2'd2);
        end
        tan_sing = (func == 2'd2) && ((r_lo == 16'sd90) || (r_lo == 16'sd270));
    end

    // State register; reset abandons any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and the handshake strobes decoded from the current state
    always_comb begin
        state_nx     = state;
        cmd_ready    = 1'b0;
        cordic_valid = 1'b0;
        res_valid    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nx = (bus.cmd_func == 2'd3) ? ISSUE : REDUCE;
            end
            REDUCE: if (!r_low && !r_high) state_nx = QUAD;
            QUAD:   state_nx = tan_sing ? DONE : ISSUE;
            ISSUE: begin
                cordic_valid = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (bus.cordic_out_valid) state_nx = FIX;
                else if (tmo_hit)         state_nx = DONE;
            end
            FIX: state_nx = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working registers: reduction accumulator, function code, sign flag, captured result
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (accept) begin
                r    <= {bus.cmd_angle[15], bus.cmd_angle};
                func <= bus.cmd_func;
                neg  <= 1'b0;
            end
            REDUCE: begin
                if (r_low)       r <= r + STEP;
                else if (r_high) r <= r - STEP;
            end
            QUAD: neg <= quad_neg;
            WAIT: if (bus.cordic_out_valid) cap <= bus.cordic_out;
            default: ;
        endcase
    end

    // Visible CORDIC operands, wait counter and the held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            angle_q   <= '0;
            sel_q     <= '0;
            another_q <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    another_q <= bus.cmd_another;
                    sel_q     <= 4'b0001 << bus.cmd_func;
                    if (bus.cmd_func == 2'd3) angle_q <= bus.cmd_angle;
                end
                QUAD: begin
                    if (tan_sing) begin
                        res_q <= 16'sh7FFF;
                        err_q <= 1'b1;
                    end else begin
                        angle_q <= quad_a;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: if (!bus.cordic_out_valid) begin
                    if (tmo_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    res_q <= neg ? neg_sat(cap) : cap;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CORDIC_FRONT_STATS_EN
    // Free-running wrap-around counts of accepted requests and WAIT timeouts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req <= '0;
            stat_tmo <= '0;
        end else begin
            if (accept) stat_req <= stat_req + 16'd1;
            if ((state == WAIT) && !bus.cordic_out_valid && tmo_hit) stat_tmo <= stat_tmo + 16'd1;
        end
    end
`endif

    assign bus.cmd_ready      = cmd_ready;
    assign bus.cordic_valid   = cordic_valid;
    assign bus.cordic_angle   = angle_q;
    assign bus.cordic_select  = sel_q;
    assign bus.cordic_another = another_q;
    assign bus.res_valid      = res_valid;
    assign bus.res_data       = res_q;
    assign bus.res_err        = err_q;
endmodule

// File: tb/tb_cordic_front.sv
// Bench for cordic_front: directed cases with hand-derived values, timeout
// boundaries, random requests against a plain-arithmetic reference, result
// backpressure and reset while waiting on the coprocessor.
module tb_cordic_front;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_front_if bus ();

`ifdef CORDIC_FRONT_STATS_EN
    logic [15:0] stat_req, stat_tmo;
`endif

    cordic_front #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CORDIC_FRONT_STATS_EN
        ,
        .stat_req (stat_req),
        .stat_tmo (stat_tmo)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [15:0] ang;
        logic [1:0]  fn;
        logic [15:0] oth;
        logic [15:0] resp;
        int          pulses;
        logic [15:0] e_ang;
        logic [3:0]  e_sel;
        logic [15:0] e_data;
        logic        e_err;
        int          e_lat;
    } dcase_t;

    // Reference: angle reduction, quadrant fold, sign tables, saturation and
    // timing expressed directly in degrees and cycle counts. e_lat counts
    // falling edges after the accepting rising edge until res_valid is seen.
    function automatic void ref_req(input int ang, input int fn, input int resp, input int lat,
                                    output int e_pulses, output int e_ang, output int e_sel,
                                    output int e_data, output int e_err, output int e_lat);
        bit [3:0] sin_neg = 4'b1100;
        bit [3:0] cos_neg = 4'b0110;
        bit [3:0] tan_neg = 4'b1010;
        int steps, r, q, sv;
        bit ng, answered;
        answered = (lat >= 1) && (lat <= TMO);
        e_sel = 1 << fn;
        e_pulses = 1;
        ng = 1'b0;
        if (fn == 3) begin
            e_ang = ang & 16'hFFFF;
            e_lat = answered ? 3 + lat : 2 + TMO;
        end else begin
            steps = (ang < 0) ? (-ang + 359) / 360 : ang / 360;
            r = ((ang % 360) + 360) % 360;
            q = (r <= 90) ? 0 : (r <= 180) ? 1 : (r <= 270) ? 2 : 3;
            e_ang = (q == 0) ? r : (q == 1) ? 180 - r : (q == 2) ? r - 180 : 360 - r;
            ng = (fn == 0) ? sin_neg[q] : (fn == 1) ? cos_neg[q] : tan_neg[q];
            if (fn == 2 && (r == 90 || r == 270)) begin
                e_pulses = 0;
                e_ang = 0;
                e_data = 16'h7FFF;
                e_err = 1;
                e_lat = steps + 3;
                return;
            end
            e_lat = answered ? steps + 5 + lat : steps + 4 + TMO;
        end
        if (!answered) begin
            e_data = 0;
            e_err = 1;
        end else begin
            sv = (resp >= 32768) ? resp - 65536 : resp;
            if (ng) sv = -sv;
            if (sv > 32767) sv = 32767;
            e_data = sv & 16'hFFFF;
            e_err = 0;
        end
    endfunction

    // Drives one request and plays the CORDIC coprocessor: the result strobe
    // arrives in the lat-th WAIT cycle (lat=0: never). Observes the issue
    // pulse, operand stability while waiting, the result and its latency.
    task automatic run_req(input logic [15:0] ang, input logic [1:0] fn, input logic [15:0] oth,
                           input logic [15:0] resp, input int lat,
                           output int pulses, output logic [15:0] i_ang, output logic [3:0] i_sel,
                           output logic [15:0] i_oth, output bit stable,
                           output logic [15:0] r_data, output logic r_err, output int lat_cyc);
        int cd;
        bit watch;
        pulses = 0; i_ang = '0; i_sel = '0; i_oth = '0; stable = 1'b1;
        r_data = '0; r_err = 1'b0; lat_cyc = -1; cd = 0; watch = 1'b0;
        @(negedge clk);
        bus.res_ready   = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_angle   = ang;
        bus.cmd_func    = fn;
        bus.cmd_another = oth;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.cordic_out_valid = 1'b0;
            if (bus.res_valid === 1'b1) begin
                r_data = bus.res_data;
                r_err = bus.res_err;
                lat_cyc = cyc;
                break;
            end
            if (watch) begin
                if (bus.cordic_angle !== i_ang || bus.cordic_select !== i_sel ||
                    bus.cordic_another !== i_oth) stable = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.cordic_out = resp;
                        bus.cordic_out_valid = 1'b1;
                        watch = 1'b0;
                    end
                end
            end
            if (bus.cordic_valid === 1'b1) begin
                pulses++;
                i_ang = bus.cordic_angle;
                i_sel = bus.cordic_select;
                i_oth = bus.cordic_another;
                watch = 1'b1;
                cd = lat;
            end
        end
        @(negedge clk);
        bus.cordic_out_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, bus.cordic_valid, bus.res_valid, bus.res_err} !== 4'b1000)
            $display("FAIL reset_strobes: got %b want 1000",
                     {bus.cmd_ready, bus.cordic_valid, bus.res_valid, bus.res_err});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.cordic_angle, bus.cordic_select, bus.cordic_another, bus.res_data} !== 52'd0)
            $display("FAIL reset_data: got %h want 0",
                     {bus.cordic_angle, bus.cordic_select, bus.cordic_another, bus.res_data});
        else n_pass++;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        else n_pass++;
`ifdef CORDIC_FRONT_STATS_EN
        n_checks++;
        if ({stat_req, stat_tmo} !== 32'd0) $display("FAIL reset_stats: got %h want 0", {stat_req, stat_tmo});
        else n_pass++;
`endif
    endtask

    task automatic test_directed();
        dcase_t tbl[14];
        int pulses, lat_cyc;
        logic [15:0] i_ang, i_oth, r_data;
        logic [3:0] i_sel;
        logic r_err;
        bit stable;
        //          ang       fn    oth       resp      p  e_ang     sel      e_data    err  lat
        tbl[0]  = '{16'd30,   2'd0, 16'h1111, 16'h0080, 1, 16'd30,   4'b0001, 16'h0080, 1'b0, 7};
        tbl[1]  = '{16'd210,  2'd0, 16'h2222, 16'h0080, 1, 16'd30,   4'b0001, 16'hFF80, 1'b0, 7};
        tbl[2]  = '{16'hFF88, 2'd1, 16'h3333, 16'h0080, 1, 16'd60,   4'b0010, 16'hFF80, 1'b0, 8};
        tbl[3]  = '{16'd90,   2'd2, 16'h4444, 16'h0100, 0, 16'd0,    4'b0100, 16'h7FFF, 1'b1, 3};
        tbl[4]  = '{16'd270,  2'd2, 16'h5555, 16'h0100, 0, 16'd0,    4'b0100, 16'h7FFF, 1'b1, 3};
        tbl[5]  = '{16'h7FFF, 2'd0, 16'h6666, 16'h001F, 1, 16'd7,    4'b0001, 16'h001F, 1'b0, 98};
        tbl[6]  = '{16'h8000, 2'd0, 16'h7777, 16'h0010, 1, 16'd8,    4'b0001, 16'hFFF0, 1'b0, 99};
        tbl[7]  = '{16'd100,  2'd3, 16'd200,  16'h0076, 1, 16'd100,  4'b1000, 16'h0076, 1'b0, 5};
        tbl[8]  = '{16'hFF9C, 2'd3, 16'h0030, 16'hFF8A, 1, 16'hFF9C, 4'b1000, 16'hFF8A, 1'b0, 5};
        tbl[9]  = '{16'd200,  2'd0, 16'h0101, 16'h8000, 1, 16'd20,   4'b0001, 16'h7FFF, 1'b0, 7};
        tbl[10] = '{16'd90,   2'd1, 16'h0202, 16'h0005, 1, 16'd90,   4'b0010, 16'h0005, 1'b0, 7};
        tbl[11] = '{16'd270,  2'd1, 16'h0303, 16'h0005, 1, 16'd90,   4'b0010, 16'hFFFB, 1'b0, 7};
        tbl[12] = '{16'd180,  2'd2, 16'h0404, 16'h0003, 1, 16'd0,    4'b0100, 16'hFFFD, 1'b0, 7};
        tbl[13] = '{16'd450,  2'd2, 16'h0505, 16'h0003, 0, 16'd0,    4'b0100, 16'h7FFF, 1'b1, 4};
        for (int i = 0; i < 14; i++) begin
            run_req(tbl[i].ang, tbl[i].fn, tbl[i].oth, tbl[i].resp, 2,
                    pulses, i_ang, i_sel, i_oth, stable, r_data, r_err, lat_cyc);
            n_checks++;
            if (pulses !== tbl[i].pulses)
                $display("FAIL dir%0d_pulses: got %0d want %0d", i, pulses, tbl[i].pulses);
            else n_pass++;
            n_checks++;
            if ({r_data, r_err} !== {tbl[i].e_data, tbl[i].e_err})
                $display("FAIL dir%0d_result: got %h/%b want %h/%b", i, r_data, r_err, tbl[i].e_data, tbl[i].e_err);
            else n_pass++;
            n_checks++;
            if (lat_cyc !== tbl[i].e_lat)
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat_cyc, tbl[i].e_lat);
            else n_pass++;
            if (tbl[i].pulses == 1) begin
                n_checks++;
                if ({i_ang, i_sel, i_oth, stable} !== {tbl[i].e_ang, tbl[i].e_sel, tbl[i].oth, 1'b1})
                    $display("FAIL dir%0d_issue: got %h/%b/%h/%b want %h/%b/%h/1", i, i_ang, i_sel, i_oth,
                             stable, tbl[i].e_ang, tbl[i].e_sel, tbl[i].oth);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int pulses, lat_cyc;
        logic [15:0] i_ang, i_oth, r_data;
        logic [3:0] i_sel;
        logic r_err;
        bit stable;
`ifdef CORDIC_FRONT_STATS_EN
        logic [15:0] req0, tmo0;
        req0 = stat_req;
        tmo0 = stat_tmo;
`endif
        // silent coprocessor: TMO cycles in WAIT, then error result
        run_req(16'd45, 2'd0, 16'h0, 16'h00B5, 0, pulses, i_ang, i_sel, i_oth, stable, r_data, r_err, lat_cyc);
        n_checks++;
        if ({r_data, r_err, stable} !== {16'h0000, 1'b1, 1'b1})
            $display("FAIL tmo_silent: got %h/%b/%b want 0000/1/1", r_data, r_err, stable);
        else n_pass++;
        n_checks++;
        if (lat_cyc !== 4 + TMO) $display("FAIL tmo_silent_lat: got %0d want %0d", lat_cyc, 4 + TMO);
        else n_pass++;
        // strobe in the last WAIT cycle is still taken
        run_req(16'd7, 2'd3, 16'd9, 16'h0123, TMO, pulses, i_ang, i_sel, i_oth, stable, r_data, r_err, lat_cyc);
        n_checks++;
        if ({r_data, r_err} !== {16'h0123, 1'b0} || lat_cyc !== 3 + TMO)
            $display("FAIL tmo_edge_ok: got %h/%b lat %0d want 0123/0 lat %0d", r_data, r_err, lat_cyc, 3 + TMO);
        else n_pass++;
        // one cycle later is too late
        run_req(16'd7, 2'd3, 16'd9, 16'h0123, TMO + 1, pulses, i_ang, i_sel, i_oth, stable, r_data, r_err, lat_cyc);
        n_checks++;
        if ({r_data, r_err} !== {16'h0000, 1'b1} || lat_cyc !== 2 + TMO)
            $display("FAIL tmo_edge_late: got %h/%b lat %0d want 0000/1 lat %0d", r_data, r_err, lat_cyc, 2 + TMO);
        else n_pass++;
`ifdef CORDIC_FRONT_STATS_EN
        n_checks++;
        if ({stat_req - req0, stat_tmo - tmo0} !== {16'd3, 16'd2})
            $display("FAIL tmo_stats: got %0d/%0d want 3/2", stat_req - req0, stat_tmo - tmo0);
        else n_pass++;
`endif
    endtask

    task automatic test_random_back_to_back();
        int pulses, lat_cyc, lat, base;
        logic [15:0] ang, oth, resp, i_ang, i_oth, r_data;
        logic [1:0] fn;
        logic [3:0] i_sel;
        logic r_err;
        bit stable;
        int e_pulses, e_ang, e_sel, e_data, e_err, e_lat;
        for (int i = 0; i < 40; i++) begin
            ang = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                base = int'($urandom_range(0, 8)) * 90 - 360;
                ang = 16'(base);
            end
            fn = 2'($urandom_range(0, 3));
            oth = 16'($urandom);
            resp = 16'($urandom);
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            ref_req(int'($signed(ang)), int'(fn), int'(resp), lat, e_pulses, e_ang, e_sel, e_data, e_err, e_lat);
            run_req(ang, fn, oth, resp, lat, pulses, i_ang, i_sel, i_oth, stable, r_data, r_err, lat_cyc);
            n_checks++;
            if ({pulses, 16'(r_data), r_err, lat_cyc} !== {e_pulses, 16'(e_data), 1'(e_err), e_lat})
                $display("FAIL rnd%0d_result ang=%h fn=%0d: got p%0d %h/%b lat %0d want p%0d %h/%0d lat %0d",
                         i, ang, fn, pulses, r_data, r_err, lat_cyc, e_pulses, 16'(e_data), e_err, e_lat);
            else n_pass++;
            if (e_pulses == 1) begin
                n_checks++;
                if ({i_ang, i_sel, i_oth, stable} !== {16'(e_ang), 4'(e_sel), oth, 1'b1})
                    $display("FAIL rnd%0d_issue ang=%h fn=%0d: got %h/%b/%h/%b want %h/%b/%h/1", i, ang, fn,
                             i_ang, i_sel, i_oth, stable, 16'(e_ang), 4'(e_sel), oth);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen, ok;
        logic [15:0] held;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = 16'd45;
        bus.cmd_func = 2'd0;
        bus.cmd_another = 16'h0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            seen = (bus.cordic_valid === 1'b1);
        end
        @(negedge clk);
        bus.cordic_out = 16'h00B5;
        bus.cordic_out_valid = 1'b1;
        @(negedge clk);
        bus.cordic_out_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.res_valid === 1'b1);
        end
        n_checks++;
        if ({seen, bus.res_data, bus.res_err} !== {1'b1, 16'h00B5, 1'b0})
            $display("FAIL bp_result: got %b/%h/%b want 1/00b5/0", seen, bus.res_data, bus.res_err);
        else n_pass++;
        held = bus.res_data;
        ok = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_func = 2'd1;
        repeat (10) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.cmd_ready !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) $display("FAIL bp_hold: got %b want 1", ok);
        else n_pass++;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.res_valid, bus.cmd_ready} !== 2'b01)
            $display("FAIL bp_release: got %b want 01", {bus.res_valid, bus.cmd_ready});
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bit seen, ok;
        int pulses, lat_cyc;
        logic [15:0] i_ang, i_oth, r_data;
        logic [3:0] i_sel;
        logic r_err;
        bit stable;
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = 16'd55;
        bus.cmd_func = 2'd3;
        bus.cmd_another = 16'd77;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            seen = (bus.cordic_valid === 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seen, bus.cmd_ready, bus.cordic_angle, bus.cordic_another} !== {1'b1, 1'b1, 32'd0})
            $display("FAIL rstw_abort: got %b/%b/%h/%h want 1/1/0000/0000", seen, bus.cmd_ready,
                     bus.cordic_angle, bus.cordic_another);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.cordic_out = 16'h1234;
        bus.cordic_out_valid = 1'b1;
        @(negedge clk);
        bus.cordic_out_valid = 1'b0;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.res_data !== 16'h0000) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rstw_late_strobe: got %b want 1", ok);
        else n_pass++;
        run_req(16'd30, 2'd0, 16'h0, 16'h0080, 1, pulses, i_ang, i_sel, i_oth, stable, r_data, r_err, lat_cyc);
        n_checks++;
        if ({r_data, r_err, lat_cyc} !== {16'h0080, 1'b0, 6})
            $display("FAIL rstw_recover: got %h/%b lat %0d want 0080/0 lat 6", r_data, r_err, lat_cyc);
        else n_pass++;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_angle = '0;
        bus.cmd_func = '0;
        bus.cmd_another = '0;
        bus.cordic_out = '0;
        bus.cordic_out_valid = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_directed();
        test_timeout();
        test_random_back_to_back();
        test_backpressure();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
